decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: datapath width of out_imm; legal values 32 or 64.
REQ-002 The block SHALL have parameter DEPTH, default 2: output queue entries; legal values 1 to 8.
REQ-003 The block SHALL have parameter CNT_W, default 8: width of illegal_count.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: discard all queued decodes.
REQ-007 The block SHALL have port in_valid, input, 1 bit: instruction word present.
REQ-008 The block SHALL have port in_instr, input, 32 bits: the instruction word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the stage can accept a word.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-012 The block SHALL have port out_class, output, 4 bits: datapath class code (REQ-018).
REQ-013 The block SHALL have ports out_rs, out_rt and out_rd, output, 5 bits each: register fields.
REQ-014 The block SHALL have port out_imm, output, XLEN bits: the extended immediate.
REQ-015 The block SHALL have port out_illegal, output, 1 bit: the head is an unknown encoding.
REQ-016 The block SHALL have port illegal_count, output, CNT_W bits: the number of accepted illegal words.

Function
REQ-017 Decode SHALL use opcode = in_instr[31:26] and funct = in_instr[5:0]; rs = [25:21], rt = [20:16], rd = [15:11].
REQ-018 Classes SHALL be mapped as follows:
- ALU = 1: addi 001000, addiu 001001; R-type add/sub/addu/subu.
- LOGIC = 2: andi 001100, ori 001101; R-type and/or.
- LOAD = 3: lw 100011.
- STORE = 4: sw 101011.
- BEQ = 5: 000100.
- BNE = 6: 000101.
- BGT = 7: 000111.
- BLE = 8: 000001, 000110.
- SLT = 9: slti 001010; R-type slt.
- JUMP = 10: j 000010, jal 000011; R-type funct 001000 (jr).
- SHIFT = 11: R-type sll 000000, srl 000010.
- ILLEGAL = 15: every other opcode, and every other funct under opcode 000000.
REQ-019 out_imm SHALL be the zero-extension of [15:0] for andi and ori, the sign-extension of [15:0] for all other I-type and branch words, the zero-extension of [25:0] for j and jal, and zero otherwise.
REQ-020 out_illegal SHALL be 1 exactly when out_class is 15.
REQ-021 A word SHALL be accepted when in_valid and in_ready are both 1; its decode SHALL be written to the queue tail and becomes visible at the head no earlier than the next cycle (latency 1 when the queue is empty).
REQ-022 The queue SHALL be a circular buffer of DEPTH entries with wrapping read/write pointers and an occupancy count of 0 to DEPTH.
REQ-023 in_ready SHALL be 1 exactly when occupancy < DEPTH; when full, a simultaneous pop SHALL NOT admit a push in the same cycle.
REQ-024 out_valid SHALL be 1 exactly when occupancy > 0; the head SHALL be popped when out_valid and out_ready are both 1.
REQ-025 A simultaneous push and pop at 0 < occupancy < DEPTH SHALL leave occupancy unchanged.
REQ-026 Output fields SHALL be held stable while out_valid is 1 and out_ready is 0.
REQ-027 flush SHALL set occupancy and both pointers to 0 on the next edge and drop any word presented in the same cycle; illegal_count SHALL be unaffected by flush.
REQ-028 illegal_count SHALL increment by 1 for each accepted ILLEGAL word and saturate at all-ones.

Reset
REQ-029 On rst, occupancy, pointers and illegal_count SHALL be set to 0, giving out_valid = 0 and in_ready = 1; reset SHALL override flush, push and pop, including mid-transfer.
REQ-030 While out_valid is 0, out_class, out_rs, out_rt, out_rd, out_imm and out_illegal SHALL read 0.

Structure
REQ-031 The class codes, the opcode and funct constants, and a packed decode-entry type SHALL live in a shared package, decode_pkg.
REQ-032 Combinational decode SHALL be one sub-module, decode_comb (instruction in, entry out); the queue and the counter SHALL be in decode_stage.

Verification
REQ-033 The bench SHALL cover each of the following directed scenarios:
- Accept 0x2129000A into an empty queue -> next cycle out_valid = 1, class 1, rs = 9, rt = 9, imm = 0x0000000A.
- Accept 0x2129FFFF -> imm = 0xFFFFFFFF. Accept 0x35298000 -> class 2, imm = 0x00008000.
- Accept 0x01095020 -> class 1, rs = 8, rt = 9, rd = 10. Accept 0xFC000000 -> class 15, out_illegal = 1, illegal_count = 1.
- With DEPTH = 2 and out_ready = 0, push 3 words -> in_ready = 0 after 2; pulsing out_ready for one cycle with in_valid held -> exactly one pop, and the third word is accepted the cycle after.
- With 2 entries queued, assert flush together with in_valid -> out_valid = 0 and in_ready = 1 next cycle; illegal_count unchanged.
- Preload illegal_count to 255 (CNT_W = 8) and accept an illegal word -> illegal_count stays 255; assert rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and the packed decode-entry type for the decode stage.
// Class codes are what downstream datapath control keys on; opcode/funct values follow the MIPS-like encoding.
package decode_pkg;

  localparam logic [3:0] CLS_NONE    = 4'd0;
  localparam logic [3:0] CLS_ALU     = 4'd1;
  localparam logic [3:0] CLS_LOGIC   = 4'd2;
  localparam logic [3:0] CLS_LOAD    = 4'd3;
  localparam logic [3:0] CLS_STORE   = 4'd4;
  localparam logic [3:0] CLS_BEQ     = 4'd5;
  localparam logic [3:0] CLS_BNE     = 4'd6;
  localparam logic [3:0] CLS_BGT     = 4'd7;
  localparam logic [3:0] CLS_BLE     = 4'd8;
  localparam logic [3:0] CLS_SLT     = 4'd9;
  localparam logic [3:0] CLS_JUMP    = 4'd10;
  localparam logic [3:0] CLS_SHIFT   = 4'd11;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLE_A = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLE_B = 6'b000110;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // imm is carried at the widest legal XLEN; the stage truncates to its own width.
  typedef struct packed {
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        illegal;
  } decode_entry_t;

  function automatic logic [63:0] sext16(input logic [15:0] v);
    return {{48{v[15]}}, v};
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational instruction decode: one 32-bit word in, one decode entry out.
module decode_comb
  import decode_pkg::*;
(
  input  logic [31:0]   i_instr,
  output decode_entry_t o_entry
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];

  always_comb begin
    o_entry     = '0;
    o_entry.rs  = i_instr[25:21];
    o_entry.rt  = i_instr[20:16];
    o_entry.rd  = i_instr[15:11];
    o_entry.cls = CLS_ILLEGAL;

    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU: o_entry.cls = CLS_ALU;
          FN_AND, FN_OR:                    o_entry.cls = CLS_LOGIC;
          FN_SLT:                           o_entry.cls = CLS_SLT;
          FN_JR:                            o_entry.cls = CLS_JUMP;
          FN_SLL, FN_SRL:                   o_entry.cls = CLS_SHIFT;
          default:                          o_entry.cls = CLS_ILLEGAL;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        o_entry.cls = CLS_ALU;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_ANDI, OP_ORI: begin
        o_entry.cls = CLS_LOGIC;
        o_entry.imm = {48'd0, i_instr[15:0]};
      end
      OP_SLTI: begin
        o_entry.cls = CLS_SLT;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_LW: begin
        o_entry.cls = CLS_LOAD;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_SW: begin
        o_entry.cls = CLS_STORE;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_BEQ: begin
        o_entry.cls = CLS_BEQ;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_BNE: begin
        o_entry.cls = CLS_BNE;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_BGT: begin
        o_entry.cls = CLS_BGT;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_BLE_A, OP_BLE_B: begin
        o_entry.cls = CLS_BLE;
        o_entry.imm = sext16(i_instr[15:0]);
      end
      OP_J, OP_JAL: begin
        o_entry.cls = CLS_JUMP;
        o_entry.imm = {38'd0, i_instr[25:0]};
      end
      default: o_entry.cls = CLS_ILLEGAL;
    endcase

    o_entry.illegal = (o_entry.cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: combinational decode into a DEPTH-entry circular output queue,
// with a saturating count of accepted illegal words that survives flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_class,
  output logic [4:0]       out_rs,
  output logic [4:0]       out_rt,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  decode_entry_t    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_illegal_count;

  decode_entry_t w_entry;
  decode_entry_t w_head;
  decode_entry_t w_out;
  logic          w_push;
  logic          w_pop;
  logic          w_unused_imm;

  decode_comb u_decode_comb (
    .i_instr (in_instr),
    .o_entry (w_entry)
  );

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // in_ready looks only at occupancy, so a full queue never admits a push even when popping.
  assign in_ready  = (r_occ < OCC_FULL);
  assign out_valid = (r_occ != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr          <= '0;
      r_rptr          <= '0;
      r_occ           <= '0;
      r_illegal_count <= '0;
    end else begin
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_push) r_wptr <= ptr_next(r_wptr);
        if (w_pop)  r_rptr <= ptr_next(r_rptr);
        case ({w_push, w_pop})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
      if (w_push && w_entry.illegal && (r_illegal_count != '1))
        r_illegal_count <= r_illegal_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_entry;
  end

  assign w_head = r_mem[r_rptr];
  assign w_out  = out_valid ? w_head : '0;

  assign out_class     = w_out.cls;
  assign out_rs        = w_out.rs;
  assign out_rt        = w_out.rt;
  assign out_rd        = w_out.rd;
  assign out_imm       = w_out.imm[XLEN-1:0];
  assign out_illegal   = w_out.illegal;
  assign illegal_count = r_illegal_count;
  assign w_unused_imm  = ^w_out.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a decode vector table plus directed
// backpressure, flush, saturation and reset sequences.
module tb_decode_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_instr;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_class;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_imm;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  int checks = 0;
  int errors = 0;

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_class     (out_class),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_illegal   (out_illegal),
    .illegal_count (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cls;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[18];
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_empty_outputs(input string tag);
    chk({tag, " out_valid"},   out_valid,   0);
    chk({tag, " out_class"},   out_class,   0);
    chk({tag, " out_rs"},      out_rs,      0);
    chk({tag, " out_rt"},      out_rt,      0);
    chk({tag, " out_rd"},      out_rd,      0);
    chk({tag, " out_imm"},     out_imm,     0);
    chk({tag, " out_illegal"}, out_illegal, 0);
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{32'h2129000A, 4'd1,  5'd9,  5'd9,  5'd0,  32'h0000000A, 1'b0};
    vecs[1]  = '{32'h2129FFFF, 4'd1,  5'd9,  5'd9,  5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{32'h35298000, 4'd2,  5'd9,  5'd9,  5'd16, 32'h00008000, 1'b0};
    vecs[3]  = '{32'h01095020, 4'd1,  5'd8,  5'd9,  5'd10, 32'h00000000, 1'b0};
    vecs[4]  = '{32'hFC000000, 4'd15, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};
    vecs[5]  = '{32'h8D280004, 4'd3,  5'd9,  5'd8,  5'd0,  32'h00000004, 1'b0};
    vecs[6]  = '{32'hAD28FFFC, 4'd4,  5'd9,  5'd8,  5'd31, 32'hFFFFFFFC, 1'b0};
    vecs[7]  = '{32'h08000010, 4'd10, 5'd0,  5'd0,  5'd0,  32'h00000010, 1'b0};
    vecs[8]  = '{32'h0FFFFFFF, 4'd10, 5'd31, 5'd31, 5'd31, 32'h03FFFFFF, 1'b0};
    vecs[9]  = '{32'h1109FFFE, 4'd5,  5'd8,  5'd9,  5'd31, 32'hFFFFFFFE, 1'b0};
    vecs[10] = '{32'h15000000, 4'd6,  5'd8,  5'd0,  5'd0,  32'h00000000, 1'b0};
    vecs[11] = '{32'h1D000003, 4'd7,  5'd8,  5'd0,  5'd0,  32'h00000003, 1'b0};
    vecs[12] = '{32'h04000005, 4'd8,  5'd0,  5'd0,  5'd0,  32'h00000005, 1'b0};
    vecs[13] = '{32'h00094080, 4'd11, 5'd0,  5'd9,  5'd8,  32'h00000000, 1'b0};
    vecs[14] = '{32'h0109502A, 4'd9,  5'd8,  5'd9,  5'd10, 32'h00000000, 1'b0};
    vecs[15] = '{32'h03E00008, 4'd10, 5'd31, 5'd0,  5'd0,  32'h00000000, 1'b0};
    vecs[16] = '{32'h3129FFFF, 4'd2,  5'd9,  5'd9,  5'd31, 32'h0000FFFF, 1'b0};
    vecs[17] = '{32'h0000003F, 4'd15, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk_empty_outputs("reset");
    chk("reset in_ready", in_ready, 1);
    chk("reset illegal_count", illegal_count, 0);

    // Decode table: push one word into the empty queue, check next cycle, then pop.
    exp_cnt = '0;
    for (int i = 0; i < 18; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      tick();
      in_valid = 1'b0;
      if (vecs[i].ill) exp_cnt = exp_cnt + 1'b1;
      chk($sformatf("v%0d out_valid", i),   out_valid,     1);
      chk($sformatf("v%0d out_class", i),   out_class,     vecs[i].cls);
      chk($sformatf("v%0d out_rs", i),      out_rs,        vecs[i].rs);
      chk($sformatf("v%0d out_rt", i),      out_rt,        vecs[i].rt);
      chk($sformatf("v%0d out_rd", i),      out_rd,        vecs[i].rd);
      chk($sformatf("v%0d out_imm", i),     out_imm,       vecs[i].imm);
      chk($sformatf("v%0d out_illegal", i), out_illegal,   vecs[i].ill);
      chk($sformatf("v%0d illegal_cnt", i), illegal_count, exp_cnt);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk_empty_outputs($sformatf("v%0d popped", i));
    end

    // Backpressure: fill DEPTH=2, hold a third word, release exactly one pop.
    in_valid = 1'b1; in_instr = 32'h2129000A;
    tick();
    in_instr = 32'h35298000;
    tick();
    in_instr = 32'h01095020;
    chk("full in_ready", in_ready, 0);
    chk("full head class", out_class, 1);
    tick();
    chk("held in_ready", in_ready, 0);
    chk("held head imm", out_imm, 32'h0000000A);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one pop head class", out_class, 2);
    chk("one pop head imm", out_imm, 32'h00008000);
    chk("one pop in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("third accepted in_ready", in_ready, 0);
    chk("third accepted head class", out_class, 2);
    out_ready = 1'b1;
    tick();
    chk("third head class", out_class, 1);
    chk("third head rd", out_rd, 10);
    tick();
    out_ready = 1'b0;
    chk("drained out_valid", out_valid, 0);

    // Flush with two entries queued and a word presented the same cycle.
    in_valid = 1'b1; in_instr = 32'h2129000A;
    tick();
    in_instr = 32'h8D280004;
    tick();
    chk("pre-flush in_ready", in_ready, 0);
    flush = 1'b1; in_instr = 32'h1109FFFE;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk_empty_outputs("flush");
    chk("flush in_ready", in_ready, 1);
    chk("flush illegal_count", illegal_count, exp_cnt);
    in_valid = 1'b1; in_instr = 32'h35298000;
    tick();
    in_valid = 1'b0;
    chk("post-flush class", out_class, 2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post-flush drained", out_valid, 0);

    // Saturation: stream illegal words with the consumer always ready.
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFC000000;
    for (int i = 0; i < 255 - int'(exp_cnt); i++) tick();
    chk("count at 255", illegal_count, 8'd255);
    tick();
    chk("count saturated", illegal_count, 8'd255);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // Reset mid-stream with push and pop requested.
    in_valid = 1'b1; in_instr = 32'h2129000A;
    tick();
    tick();
    rst = 1'b1; out_ready = 1'b1; in_instr = 32'hFC000000;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk_empty_outputs("midrst");
    chk("midrst illegal_count", illegal_count, 0);
    chk("midrst in_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
